// File: rtl/obstacle_alert_array.sv
// Multi-channel obstacle alert: per-channel sensor sync, debounce and an escalating alert FSM.
// Optional build macro OBSTACLE_LATCH_EN: CRIT latches until ack is seen with the sensor clear.
//
// state | meaning
// IDLE  | no obstacle (or alerts disabled), buzzer off
// WARN  | obstacle present, slow blink, counting ESC_CYCLES
// NEAR  | obstacle persisted, fast blink, counting ESC_CYCLES
// CRIT  | obstacle persisted through NEAR, buzzer solid on
module obstacle_alert_array #(
  parameter int NUM_CH     = 4,
  parameter int DEBOUNCE   = 4,
  parameter int ESC_CYCLES = 256,
  parameter int SLOW_HALF  = 64,
  parameter int FAST_HALF  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     sensor,
  input  logic                  ack,
  output logic [2*NUM_CH-1:0]   buzz_level,
  output logic [NUM_CH-1:0]     buzz_drive,
  output logic                  any_alert
);

  localparam int DB_W     = $clog2(DEBOUNCE);
  localparam int ESC_W    = $clog2(ESC_CYCLES);
  localparam int BL_W     = $clog2(2 * SLOW_HALF);
  localparam int SLOW_BIT = $clog2(SLOW_HALF);
  localparam int FAST_BIT = $clog2(FAST_HALF);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [ESC_W-1:0] ESC_LAST = ESC_W'(ESC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WARN = 2'b01,
    NEAR = 2'b10,
    CRIT = 2'b11
  } state_t;

  logic [NUM_CH-1:0] s_q;
  logic [NUM_CH-1:0] det_q;
  logic [DB_W-1:0]   db_cnt_q [NUM_CH];
  logic [ESC_W-1:0]  esc_q    [NUM_CH];
  logic [ESC_W-1:0]  esc_d    [NUM_CH];
  state_t            state_q  [NUM_CH];
  state_t            state_d  [NUM_CH];
  logic [BL_W-1:0]   blink_q;
  logic [NUM_CH-1:0] drive_q;

  // Sync flop plus debounce: det only follows s after DEBOUNCE consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q   <= '0;
      det_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      s_q <= sensor;
      for (int i = 0; i < NUM_CH; i++) begin
        if (s_q[i] == det_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          det_q[i]    <= s_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        esc_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        esc_q[i]   <= esc_d[i];
      end
    end
  end

`ifndef OBSTACLE_LATCH_EN
  logic unused_ack;
  assign unused_ack = ack;
`endif

  // Clearing (det low or disabled) wins over escalation in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      esc_d[i]   = esc_q[i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!enable) begin
        state_d[i] = IDLE;
        esc_d[i]   = '0;
      end else if (!det_q[i]) begin
`ifdef OBSTACLE_LATCH_EN
        if (state_q[i] != CRIT || ack) begin
          state_d[i] = IDLE;
          esc_d[i]   = '0;
        end
`else
        state_d[i] = IDLE;
        esc_d[i]   = '0;
`endif
      end else begin
        unique case (state_q[i])
          IDLE: begin
            state_d[i] = WARN;
            esc_d[i]   = '0;
          end
          WARN: begin
            if (esc_q[i] == ESC_LAST) begin
              state_d[i] = NEAR;
              esc_d[i]   = '0;
            end else begin
              esc_d[i] = esc_q[i] + 1'b1;
            end
          end
          NEAR: begin
            if (esc_q[i] == ESC_LAST) begin
              state_d[i] = CRIT;
              esc_d[i]   = '0;
            end else begin
              esc_d[i] = esc_q[i] + 1'b1;
            end
          end
          CRIT: begin
            state_d[i] = CRIT;
            esc_d[i]   = '0;
          end
          default: begin
            state_d[i] = IDLE;
            esc_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Shared blink timebase; both blink rates are bits of the same counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drive_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        unique case (state_q[i])
          IDLE:    drive_q[i] <= 1'b0;
          WARN:    drive_q[i] <= blink_q[SLOW_BIT];
          NEAR:    drive_q[i] <= blink_q[FAST_BIT];
          CRIT:    drive_q[i] <= 1'b1;
          default: drive_q[i] <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    buzz_level = '0;
    any_alert  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      buzz_level[2*i +: 2] = state_q[i];
      any_alert            = any_alert | (state_q[i] != IDLE);
    end
  end

  assign buzz_drive = drive_q;

endmodule

// File: tb/tb_obstacle_alert_array.sv
// Bench for obstacle_alert_array: table-driven vectors plus timed sequences, checked through a
// time-ordered scoreboard of expected level/alert/drive values.
module tb_obstacle_alert_array;

  localparam int NUM_CH     = 4;
  localparam int DEBOUNCE   = 4;
  localparam int ESC_CYCLES = 256;
  localparam int LAT        = DEBOUNCE + 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b1;
  logic                ack = 1'b0;
  logic [NUM_CH-1:0]   sensor = 4'hF;
  logic [2*NUM_CH-1:0] buzz_level;
  logic [NUM_CH-1:0]   buzz_drive;
  logic                any_alert;

  obstacle_alert_array #(
    .NUM_CH(NUM_CH), .DEBOUNCE(DEBOUNCE), .ESC_CYCLES(ESC_CYCLES),
    .SLOW_HALF(64), .FAST_HALF(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sensor(sensor), .ack(ack),
    .buzz_level(buzz_level), .buzz_drive(buzz_drive), .any_alert(any_alert)
  );

  always #5 clk = ~clk;

  int unsigned tick = 0;
  logic [6:0]  bcnt = '0;
  always @(posedge clk) begin
    tick <= tick + 1;
    bcnt <= reset ? 7'd0 : bcnt + 7'd1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned t;
    bit          is_drv;
    logic [7:0]  val;
    string       nm;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] sen;
    logic       en;
    int         dt;
    logic [7:0] lvl;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0d)", nm, act, expv, tick);
    end
  endtask

  function automatic logic [3:0] drv_of(logic [7:0] lvl, logic [6:0] bl);
    logic [3:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      case (lvl[2*i +: 2])
        2'b00:   d[i] = 1'b0;
        2'b01:   d[i] = bl[6];
        2'b10:   d[i] = bl[4];
        default: d[i] = 1'b1;
      endcase
    end
    return d;
  endfunction

  task automatic push(exp_t e);
    int k;
    k = sb.size();
    while (k > 0 && sb[k-1].t > e.t) k--;
    sb.insert(k, e);
  endtask

  // Level/alert expected dt edges from now; drive expected one edge later from that level.
  task automatic expect_lvl(int dt, logic [7:0] lvl, string nm);
    exp_t e;
    e.t = tick + dt; e.is_drv = 1'b0; e.val = lvl; e.nm = nm;
    push(e);
    e.t = tick + dt + 1; e.is_drv = 1'b1;
    e.val = {4'h0, drv_of(lvl, bcnt + 7'(dt))};
    push(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].t <= tick) begin
      exp_t e;
      e = sb.pop_front();
      if (e.t < tick) begin
        checks++;
        errors++;
        $display("FAIL %s missed slot actual_t=%0d expected_t=%0d", e.nm, tick, e.t);
      end else if (e.is_drv) begin
        chk({e.nm, "_drv"}, 32'(buzz_drive), 32'(e.val[3:0]));
      end else begin
        chk(e.nm, 32'(buzz_level), 32'(e.val));
        chk({e.nm, "_alert"}, 32'(any_alert), 32'(e.val != 8'h00));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int unsigned maxc);
    int unsigned n;
    n = 0;
    while (sb.size() > 0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual_pending=%0d expected_pending=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] prev;
    logic [7:0] l1;

    tbl[0] = '{4'b0001, 1'b1, LAT, 8'h01};
    tbl[1] = '{4'b0011, 1'b1, LAT, 8'h05};
    tbl[2] = '{4'b1010, 1'b1, LAT, 8'h44};
    tbl[3] = '{4'b1010, 1'b0, 1,   8'h00};
    tbl[4] = '{4'b1010, 1'b1, 1,   8'h44};
    tbl[5] = '{4'b0101, 1'b1, LAT, 8'h11};
    tbl[6] = '{4'b1111, 1'b1, LAT, 8'h55};
    tbl[7] = '{4'b0000, 1'b1, LAT, 8'h00};

    // Reset held with all sensors active, then release.
    repeat (3) begin
      @(negedge clk);
      chk("rst_level", 32'(buzz_level), 32'h0);
      chk("rst_drive", 32'(buzz_drive), 32'h0);
      chk("rst_alert", 32'(any_alert), 32'h0);
    end
    step();
    reset = 1'b0;
    expect_lvl(LAT - 1, 8'h00, "rel_pre");
    expect_lvl(LAT, 8'h55, "rel_warn");
    drain(20);
    step();
    sensor = 4'h0;
    expect_lvl(LAT - 1, 8'h55, "all_fall_pre");
    expect_lvl(LAT, 8'h00, "all_fall");
    drain(20);

    // Glitch shorter than DEBOUNCE, then exactly DEBOUNCE long.
    step();
    sensor = 4'b0001;
    expect_lvl(LAT, 8'h00, "glitch3");
    expect_lvl(LAT + 3, 8'h00, "glitch3_late");
    repeat (3) step();
    sensor = 4'b0000;
    drain(20);
    step();
    sensor = 4'b0001;
    expect_lvl(LAT - 1, 8'h00, "p4_pre");
    expect_lvl(LAT, 8'h01, "p4_warn");
    expect_lvl(LAT + 3, 8'h01, "p4_hold");
    expect_lvl(LAT + 4, 8'h00, "p4_fall");
    repeat (4) step();
    sensor = 4'b0000;
    drain(30);

    prev = 8'h00;
    for (int k = 0; k < 8; k++) begin
      step();
      sensor = tbl[k].sen;
      enable = tbl[k].en;
      expect_lvl(tbl[k].dt - 1, prev, $sformatf("tbl%0d_pre", k));
      expect_lvl(tbl[k].dt, tbl[k].lvl, $sformatf("tbl%0d", k));
      prev = tbl[k].lvl;
      drain(20);
    end

    // Channel 1 escalation WARN -> NEAR -> CRIT with blink checks along the way.
    step();
    sensor = 4'b0010;
    for (int k = LAT - 1; k <= LAT + 2 * ESC_CYCLES + 12; k += 3) begin
      if (k < LAT) l1 = 8'h00;
      else if (k < LAT + ESC_CYCLES) l1 = 8'h04;
      else if (k < LAT + 2 * ESC_CYCLES) l1 = 8'h08;
      else l1 = 8'h0C;
      expect_lvl(k, l1, $sformatf("esc_k%0d", k));
    end
    expect_lvl(LAT + ESC_CYCLES - 1, 8'h04, "warn_last");
    expect_lvl(LAT + ESC_CYCLES, 8'h08, "near_first");
    expect_lvl(LAT + 2 * ESC_CYCLES - 1, 8'h08, "near_last");
    expect_lvl(LAT + 2 * ESC_CYCLES, 8'h0C, "crit_first");
    drain(600);

    // ack while the obstacle is still present changes nothing.
    step();
    ack = 1'b1;
    expect_lvl(1, 8'h0C, "ack_det_hi");
    expect_lvl(3, 8'h0C, "ack_det_hi_late");
    step();
    ack = 1'b0;
    drain(10);

    step();
    sensor = 4'b0000;
`ifdef OBSTACLE_LATCH_EN
    expect_lvl(LAT, 8'h0C, "latch_hold");
    expect_lvl(LAT + 10, 8'h0C, "latch_hold_late");
    drain(30);
    step();
    ack = 1'b1;
    expect_lvl(1, 8'h00, "ack_clear");
    step();
    ack = 1'b0;
    drain(10);
`else
    expect_lvl(LAT - 1, 8'h0C, "crit_drop_pre");
    expect_lvl(LAT, 8'h00, "crit_drop");
    drain(30);
`endif

    // One-cycle enable drop while channel 2 is in NEAR restarts escalation.
    step();
    sensor = 4'b0100;
    expect_lvl(LAT + ESC_CYCLES, 8'h20, "c2_near");
    drain(300);
    step();
    enable = 1'b0;
    expect_lvl(1, 8'h00, "en_off");
    step();
    enable = 1'b1;
    expect_lvl(1, 8'h10, "en_rewarn");
    expect_lvl(ESC_CYCLES, 8'h10, "restart_warn_last");
    expect_lvl(ESC_CYCLES + 1, 8'h20, "restart_near");
    drain(300);

    // Reset while channel 3 is in NEAR; full debounce latency afterwards.
    step();
    sensor = 4'b1000;
    expect_lvl(LAT, 8'h40, "c3_warn");
    expect_lvl(LAT + ESC_CYCLES, 8'h80, "c3_near");
    drain(300);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_lvl(0, 8'h00, "midrst");
    expect_lvl(LAT - 1, 8'h00, "midrst_relat_pre");
    expect_lvl(LAT, 8'h40, "midrst_relat_warn");
    @(negedge clk);
    chk("midrst_drive", 32'(buzz_drive), 32'h0);
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
